reimu_shot: RTL
===============

// Module: reimu_shot
// PURPOSE
//  Player-shot manager downstream of the player-position stage. Consumes registered
//  player x/y and a fire key; spawns upward-moving shots into a fixed slot pool on a
//  cooldown; advances, retires and reports them. Feeds the collision and VGA draw stages.
//  Retires shots on a hit reported by the collision stage.
// PARAMETERS
//  NSHOT      4   shot slots in the pool (1..8)
//  SHOT_SPEED 12  pixels moved up per clk22 tick
//  COOLDOWN   3   ticks between consecutive spawns (0 = every tick)
//  SPAWN_OFS  8   spawn y = reimuy - SPAWN_OFS
//  TOP_Y      10  playfield top edge; a shot is retired when it would pass it
// PORTS
//  clk22      in   1         game tick clock, the same clock as the player-position stage
//  rst_n      in   1         synchronous, active-low reset
//  gameover   in   1         clears the pool while high
//  fire       in   1         fire key held (level)
//  reimux     in   10        player x from the player-position stage
//  reimuy     in   10        player y from the player-position stage
//  hit        in   NSHOT     per-slot kill request from the collision stage
//  shot_valid out  NSHOT     slot i holds a live shot
//  shot_x     out  10*NSHOT  slot i x at bits [10i+9:10i]
//  shot_y     out  10*NSHOT  slot i y at bits [10i+9:10i]
//  shot_cnt   out  4         number of live shots (popcount of shot_valid)
// BEHAVIOUR
//  Reset: if !rst_n or gameover on a clk22 edge:
//   - shot_valid=0, shot_x=0, shot_y=0, shot_cnt=0.
//   - Cooldown counter cd=0.
//  All outputs are registered. shot_cnt is the popcount of the registered valids.
//  Per tick, for each slot i where valid[i]=1, in priority order:
//   1. hit[i]=1 -> valid[i]<=0 (hit wins over move).
//   2. else if y[i] < TOP_Y+SHOT_SPEED -> valid[i]<=0 (off the top; no wrap-around).
//   3. else y[i] <= y[i]-SHOT_SPEED; x[i] unchanged.
//  hit[i] on an invalid slot is ignored.
//  Spawn condition: fire=1 AND cd=0 AND at least one slot has valid=0 in the *current*
//   registered state AND reimuy >= TOP_Y+SPAWN_OFS.
//   - A slot freed this tick is not reusable until the next tick.
//  On spawn:
//   - The lowest-index free slot j gets valid<=1, x<=reimux, y<=reimuy-SPAWN_OFS.
//   - That shot does not move on the spawn tick.
//   - cd<=COOLDOWN.
//  Otherwise: if cd>0, cd<=cd-1. Blocked fire (pool full or spawn y out of range)
//   does not reload cd.
//  Latency: a fire sampled at edge k makes the shot visible on the outputs after edge k.
//  Holding fire with COOLDOWN=C spawns one shot every C+1 ticks.
//  Releasing fire does not reset cd; cd keeps counting down.
//  All arithmetic is 10-bit unsigned. The retire check runs before the subtraction,
//   so y never underflows.
// STRUCTURE
//  Shared package game_pkg:
//   - Screen constants: TOP_Y, PLAY_W=440, PLAY_H=480.
//   - COORD_W=10.
//   - Slot record typedef {valid, x, y}, reused by the enemy-bullet stage.
//  One sub-module shot_slot, instanced NSHOT times:
//   - Holds valid/x/y.
//   - Inputs: load, load_x, load_y, hit.
//   - Implements rules 1-3.
//  The top level holds:
//   - The lowest-free priority encoder.
//   - The cooldown counter.
//   - The popcount.
// TESTING
//  1. rst_n=0 for 2 ticks, fire=1 -> all valids 0, shot_cnt=0. Release reset, player
//     at (220,360) -> slot0 at (220,352) one tick later.
//  2. Hold fire, COOLDOWN=3, NSHOT=4 -> spawns on ticks 0,4,8,12 into slots 0..3.
//     Tick 16 is blocked (pool full) unless slot 0 has retired; cd stays 0 while blocked.
//  3. Single shot from y=352, no hits -> y steps 340,328,...,28,16; next tick retires
//     (16<22). shot_cnt returns to 0.
//  4. hit[1]=1 on the same tick that slot 1 would move -> slot 1 invalid next tick.
//     A spawn on the same tick goes to the lowest free slot other than 1.
//  5. Player at y=17 (<18) with fire=1, cd=0 -> no spawn, cd stays 0.
//     At y=18 -> spawn at y=10.
//  6. gameover=1 mid-flight with 3 live shots -> all cleared next tick, cd=0.
//     The first fire after gameover falls spawns immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen constants and the slot record used by the shot and enemy-bullet stages.
package game_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned TOP_Y   = 10;
  localparam int unsigned PLAY_W  = 440;
  localparam int unsigned PLAY_H  = 480;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } slot_t;

endpackage

// File: rtl/shot_slot.sv
// One shot slot: holds valid/x/y, moves the shot up each tick and retires it on a hit
// or when the next step would cross the playfield top.
module shot_slot
  import game_pkg::COORD_W, game_pkg::slot_t;
#(
  parameter int unsigned SHOT_SPEED = 12,
  parameter int unsigned TOP_Y      = game_pkg::TOP_Y
) (
  input  logic               clk22,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  input  logic               hit,
  output slot_t              slot
);

  localparam logic [COORD_W-1:0] RETIRE_Y = COORD_W'(TOP_Y + SHOT_SPEED);
  localparam logic [COORD_W-1:0] STEP     = COORD_W'(SHOT_SPEED);

  slot_t slot_q, slot_d;

  // Retire check precedes the subtraction so y can never wrap.
  always_comb begin
    slot_d = slot_q;
    if (load) begin
      slot_d.valid = 1'b1;
      slot_d.x     = load_x;
      slot_d.y     = load_y;
    end else if (slot_q.valid) begin
      if (hit) begin
        slot_d.valid = 1'b0;
      end else if (slot_q.y < RETIRE_Y) begin
        slot_d.valid = 1'b0;
      end else begin
        slot_d.y = slot_q.y - STEP;
      end
    end
  end

  always_ff @(posedge clk22) begin
    if (!rst_n || clear) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/reimu_shot.sv
// Player-shot manager: spawns shots into the lowest free slot on a cooldown and
// reports the live pool to the collision and draw stages.
module reimu_shot
  import game_pkg::COORD_W, game_pkg::slot_t;
#(
  parameter int unsigned NSHOT      = 4,
  parameter int unsigned SHOT_SPEED = 12,
  parameter int unsigned COOLDOWN   = 3,
  parameter int unsigned SPAWN_OFS  = 8,
  parameter int unsigned TOP_Y      = game_pkg::TOP_Y
) (
  input  logic                     clk22,
  input  logic                     rst_n,
  input  logic                     gameover,
  input  logic                     fire,
  input  logic [COORD_W-1:0]       reimux,
  input  logic [COORD_W-1:0]       reimuy,
  input  logic [NSHOT-1:0]         hit,
  output logic [NSHOT-1:0]         shot_valid,
  output logic [COORD_W*NSHOT-1:0] shot_x,
  output logic [COORD_W*NSHOT-1:0] shot_y,
  output logic [3:0]               shot_cnt
);

  localparam int unsigned        CD_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0]    CD_RELOAD = CD_W'(COOLDOWN);
  localparam logic [COORD_W-1:0] SPAWN_MIN = COORD_W'(TOP_Y + SPAWN_OFS);
  localparam logic [COORD_W-1:0] OFS       = COORD_W'(SPAWN_OFS);

  slot_t              slots [NSHOT];
  logic [NSHOT-1:0]   free_slots;
  logic [NSHOT-1:0]   first_free;
  logic [NSHOT-1:0]   load;
  logic               found;
  logic               spawn;
  logic [COORD_W-1:0] spawn_y;
  logic [CD_W-1:0]    cd_q, cd_d;

  // Free slots come from the registered valids, so a slot freed this tick waits a tick.
  assign free_slots = ~shot_valid;

  always_comb begin
    first_free = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(NSHOT); i++) begin
      if (free_slots[i] && !found) begin
        first_free[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign spawn   = fire && (cd_q == '0) && (|free_slots) && (reimuy >= SPAWN_MIN);
  assign spawn_y = reimuy - OFS;
  assign load    = first_free & {NSHOT{spawn}};

  // Blocked fire leaves cd alone; it only reloads on an actual spawn.
  always_comb begin
    cd_d = cd_q;
    if (spawn) begin
      cd_d = CD_RELOAD;
    end else if (cd_q != '0) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  always_ff @(posedge clk22) begin
    if (!rst_n || gameover) begin
      cd_q <= '0;
    end else begin
      cd_q <= cd_d;
    end
  end

  for (genvar i = 0; i < NSHOT; i++) begin : g_slot
    shot_slot #(
      .SHOT_SPEED(SHOT_SPEED),
      .TOP_Y     (TOP_Y)
    ) u_slot (
      .clk22 (clk22),
      .rst_n (rst_n),
      .clear (gameover),
      .load  (load[i]),
      .load_x(reimux),
      .load_y(spawn_y),
      .hit   (hit[i]),
      .slot  (slots[i])
    );

    assign shot_valid[i]                   = slots[i].valid;
    assign shot_x[i*COORD_W +: COORD_W]    = slots[i].x;
    assign shot_y[i*COORD_W +: COORD_W]    = slots[i].y;
  end

  always_comb begin
    shot_cnt = '0;
    for (int i = 0; i < int'(NSHOT); i++) begin
      shot_cnt = shot_cnt + 4'(shot_valid[i]);
    end
  end

endmodule
